// File: rtl/alu_issue_stage_pkg.sv
// Shared opcode, FSM state and latency-class definitions for the Alu issue stage.
package alu_issue_stage_pkg;

    // Arithmetic opcodes (a_or_l = 0)
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    // Logic opcodes (a_or_l = 1)
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LAT_SEL_SIMPLE = 2'd0,
        LAT_SEL_MUL    = 2'd1,
        LAT_SEL_DIV    = 2'd2
    } lat_sel_e;

endpackage

// File: rtl/alu_op_decode.sv
// Classifies an op into a latency class and flags illegal opcodes and divide-by-zero.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic        a_or_l,
    input  logic [2:0]  opcode,
    input  logic [31:0] b,
    output logic [1:0]  lat_sel,
    output logic        err
);

    always_comb begin
        lat_sel = LAT_SEL_SIMPLE;
        err     = 1'b0;
        if (a_or_l) begin
            err = (opcode > OP_XOR);
        end else begin
            case (opcode)
                OP_ADD, OP_SUB: ;
                OP_MUL: lat_sel = LAT_SEL_MUL;
                OP_DIV: begin
                    lat_sel = LAT_SEL_DIV;
                    err     = (b == 32'd0);
                end
                // Illegal ops retire on the short path with a zero result.
                default: err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational/multi-cycle Alu: one-entry pending buffer,
// operand hold for an op-dependent latency, and a registered valid/ready result port.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned LAT_SIMPLE = 1,
    parameter int unsigned LAT_MUL    = 2,
    parameter int unsigned LAT_DIV    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_a_or_l,
    input  logic        in_s_or_u,
    input  logic [2:0]  in_opcode,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_a_or_l,
    output logic        alu_s_or_u,
    output logic [2:0]  alu_opcode,
    input  logic [31:0] alu_answer,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_err
);

    localparam int unsigned LAT_MAX_SM = (LAT_SIMPLE > LAT_MUL) ? LAT_SIMPLE : LAT_MUL;
    localparam int unsigned LAT_MAX    = (LAT_MAX_SM > LAT_DIV) ? LAT_MAX_SM : LAT_DIV;
    localparam int unsigned CNT_W      = $clog2(LAT_MAX) + 1;

    logic        pend_valid_q;
    logic        pend_a_or_l_q;
    logic        pend_s_or_u_q;
    logic [2:0]  pend_opcode_q;
    logic [31:0] pend_a_q;
    logic [31:0] pend_b_q;

    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic        alu_a_or_l_q;
    logic        alu_s_or_u_q;
    logic [2:0]  alu_opcode_q;
    logic        err_q;

    logic        out_valid_q;
    logic [31:0] out_result_q;
    logic        out_err_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       lat_sel;
    logic             dec_err;
    logic [CNT_W-1:0] lat_m1;
    logic             load;
    logic             launch;
    logic             capture;
    logic             out_take;

    // Decode looks at the pending entry so err/latency are ready on the launch edge.
    alu_op_decode u_decode (
        .a_or_l  (pend_a_or_l_q),
        .opcode  (pend_opcode_q),
        .b       (pend_b_q),
        .lat_sel (lat_sel),
        .err     (dec_err)
    );

    always_comb begin
        case (lat_sel)
            LAT_SEL_MUL: lat_m1 = CNT_W'(LAT_MUL - 1);
            LAT_SEL_DIV: lat_m1 = CNT_W'(LAT_DIV - 1);
            default:     lat_m1 = CNT_W'(LAT_SIMPLE - 1);
        endcase
    end

    assign in_ready = !pend_valid_q;
    assign load     = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        launch   = 1'b0;
        capture  = 1'b0;
        out_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    launch = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_take = 1'b1;
                    if (pend_valid_q) begin
                        launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch) begin
            state_d = ST_EXEC;
            cnt_d   = lat_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_a_or_l_q <= 1'b0;
            pend_s_or_u_q <= 1'b0;
            pend_opcode_q <= '0;
            pend_a_q      <= '0;
            pend_b_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_a_or_l_q  <= 1'b0;
            alu_s_or_u_q  <= 1'b0;
            alu_opcode_q  <= '0;
            err_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            // A load in the same cycle as a drain wins, keeping the new op.
            if (load) begin
                pend_valid_q  <= 1'b1;
                pend_a_or_l_q <= in_a_or_l;
                pend_s_or_u_q <= in_s_or_u;
                pend_opcode_q <= in_opcode;
                pend_a_q      <= in_a;
                pend_b_q      <= in_b;
            end else if (launch) begin
                pend_valid_q <= 1'b0;
            end

            if (launch) begin
                alu_a_q      <= pend_a_q;
                alu_b_q      <= pend_b_q;
                alu_a_or_l_q <= pend_a_or_l_q;
                alu_s_or_u_q <= pend_s_or_u_q;
                alu_opcode_q <= pend_opcode_q;
                err_q        <= dec_err;
            end

            if (capture) begin
                out_valid_q  <= 1'b1;
                out_result_q <= err_q ? 32'd0 : alu_answer;
                out_err_q    <= err_q;
            end else if (out_take) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_a_or_l = alu_a_or_l_q;
    assign alu_s_or_u = alu_s_or_u_q;
    assign alu_opcode = alu_opcode_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;

endmodule
